// File: rtl/pulse_width_meter.sv
// Measures the width of each high pulse on i_pul_in in clock cycles and hands it out with RDY/ACK.
// Define PWM_IN_SYNC_EN to put a two-flop synchronizer on i_pul_in (adds 2 cycles of latency).
module pulse_width_meter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pul_in,
  input  logic             i_en,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_w_pul_n,
  output logic             o_rdy,
  output logic             o_ovf,
  output logic             o_lost
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEAS     = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CntMax = '1;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cntNext;
  logic             r_ovf;
  logic             w_ovfNext;
  logic             w_commit;
  logic             w_s;
  logic [WIDTH-1:0] r_width;
  logic             r_rdy;
  logic             r_ovfOut;
  logic             r_lost;

`ifdef PWM_IN_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Flops reset high so a line that is idle-high after reset looks like a partial pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_pul_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_pul_in;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= WAIT_LOW;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_ovf   <= w_ovfNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_ovfNext   = r_ovf;
    w_commit    = 1'b0;
    if (!i_en) begin
      w_stateNext = WAIT_LOW;
      w_cntNext   = '0;
      w_ovfNext   = 1'b0;
    end else begin
      case (r_state)
        WAIT_LOW: begin
          if (!w_s) w_stateNext = IDLE;
        end
        IDLE: begin
          if (w_s) begin
            w_stateNext = MEAS;
            w_cntNext   = {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        MEAS: begin
          if (w_s) begin
            if (r_cnt == CntMax) w_ovfNext = 1'b1;
            else                 w_cntNext = r_cnt + 1'b1;
          end else begin
            w_commit    = 1'b1;
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_ovfNext   = 1'b0;
          end
        end
        default: begin
          w_stateNext = WAIT_LOW;
          w_cntNext   = '0;
          w_ovfNext   = 1'b0;
        end
      endcase
    end
  end

  // A commit coinciding with ACK replaces the pending result instead of counting as lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_width  <= '0;
      r_rdy    <= 1'b0;
      r_ovfOut <= 1'b0;
      r_lost   <= 1'b0;
    end else if (w_commit) begin
      if (!r_rdy || i_ack) begin
        r_width  <= r_cnt;
        r_ovfOut <= r_ovf;
        r_rdy    <= 1'b1;
      end else begin
        r_lost <= 1'b1;
      end
    end else if (i_ack && r_rdy) begin
      r_rdy  <= 1'b0;
      r_lost <= 1'b0;
    end
  end

  assign o_w_pul_n = r_width;
  assign o_rdy     = r_rdy;
  assign o_ovf     = r_ovfOut;
  assign o_lost    = r_lost;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench for pulse_width_meter: table-driven pulse/handshake vectors plus reset sequences.
// Works in both builds; with PWM_IN_SYNC_EN defined the expected timeline is shifted by the sync latency.
module tb_pulse_width_meter;

  localparam int WIDTH = 4;
`ifdef PWM_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rstN;
  logic             pulIn;
  logic             en;
  logic             ack;
  logic [WIDTH-1:0] wPul;
  logic             rdy;
  logic             ovf;
  logic             lost;

  typedef struct {
    logic             pul;
    logic             en;
    logic             ack;
    logic [WIDTH-1:0] w;
    logic             rdy;
    logic             ovf;
    logic             lost;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  pulse_width_meter #(.WIDTH(WIDTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rstN),
    .i_pul_in (pulIn),
    .i_en     (en),
    .i_ack    (ack),
    .o_w_pul_n(wPul),
    .o_rdy    (rdy),
    .o_ovf    (ovf),
    .o_lost   (lost)
  );

  always #5 clk = ~clk;

  task automatic addRows(input int n, input logic p, input logic e, input logic a,
                         input logic [WIDTH-1:0] w, input logic r, input logic o, input logic l);
    vec_t v;
    v.pul = p; v.en = e; v.ack = a; v.w = w; v.rdy = r; v.ovf = o; v.lost = l;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic p, input logic e, input logic a);
    pulIn = p;
    en    = e;
    ack   = a;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] w,
                             input logic r, input logic o, input logic l);
    total++;
    if ({wPul, rdy, ovf, lost} !== {w, r, o, l}) begin
      bad++;
      $display("[TB] FAIL %s: got w=%0d rdy=%0b ovf=%0b lost=%0b, want w=%0d rdy=%0b ovf=%0b lost=%0b",
               name, wPul, rdy, ovf, lost, w, r, o, l);
    end
  endtask

  task automatic waitRdy(input int budget);
    int k = 0;
    while (rdy !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    // 5-cycle pulse, ACK one cycle later
    addRows(5, 1, 1, 0,  0, 0, 0, 0);
    addRows(1, 0, 1, 0,  5, 1, 0, 0);
    addRows(1, 0, 1, 1,  5, 0, 0, 0);
    // 20-cycle pulse saturates, then 3-cycle pulse
    addRows(20, 1, 1, 0, 5, 0, 0, 0);
    addRows(1, 0, 1, 0, 15, 1, 1, 0);
    addRows(1, 0, 1, 1, 15, 0, 1, 0);
    addRows(3, 1, 1, 0, 15, 0, 1, 0);
    addRows(1, 0, 1, 0,  3, 1, 0, 0);
    addRows(1, 0, 1, 1,  3, 0, 0, 0);
    // exactly 15 cycles: saturated value but no overflow
    addRows(15, 1, 1, 0, 3, 0, 0, 0);
    addRows(1, 0, 1, 0, 15, 1, 0, 0);
    addRows(1, 0, 1, 1, 15, 0, 0, 0);
    // 4 then 7 with no ACK: second result lost
    addRows(4, 1, 1, 0, 15, 0, 0, 0);
    addRows(1, 0, 1, 0,  4, 1, 0, 0);
    addRows(7, 1, 1, 0,  4, 1, 0, 0);
    addRows(1, 0, 1, 0,  4, 1, 0, 1);
    addRows(1, 0, 1, 1,  4, 0, 0, 0);
    // 4 then 7 with ACK on the completion edge: new result replaces old
    addRows(4, 1, 1, 0,  4, 0, 0, 0);
    addRows(1, 0, 1, 0,  4, 1, 0, 0);
    addRows(7, 1, 1, 0,  4, 1, 0, 0);
    addRows(1, 0, 1, 1,  7, 1, 0, 0);
    addRows(1, 0, 1, 1,  7, 0, 0, 0);
    // 1-cycle pulse, 1-cycle gap, 2-cycle pulse completing with ACK
    addRows(1, 1, 1, 0,  7, 0, 0, 0);
    addRows(1, 0, 1, 0,  1, 1, 0, 0);
    addRows(2, 1, 1, 0,  1, 1, 0, 0);
    addRows(1, 0, 1, 1,  2, 1, 0, 0);
    addRows(1, 0, 1, 1,  2, 0, 0, 0);
    // EN drop mid-pulse aborts; the remaining high part is ignored
    addRows(3, 1, 1, 0,  2, 0, 0, 0);
    addRows(1, 1, 0, 0,  2, 0, 0, 0);
    addRows(2, 1, 1, 0,  2, 0, 0, 0);
    addRows(1, 0, 1, 0,  2, 0, 0, 0);
    addRows(3, 1, 1, 0,  2, 0, 0, 0);
    addRows(1, 0, 1, 0,  3, 1, 0, 0);
    addRows(1, 0, 1, 1,  3, 0, 0, 0);

    rstN  = 1'b0;
    pulIn = 1'b0;
    en    = 1'b1;
    ack   = 1'b0;
    #12;
    checkOutput("resetActive", 0, 0, 0, 0);
    tick();
    rstN = 1'b1;
    repeat (3) applyStimulus(0, 1, 0);
    checkOutput("afterReset", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size() + LAT; i++) begin
      logic p;
      logic e;
      logic a;
      p = (i < vecs.size()) ? vecs[i].pul : 1'b0;
      e = 1'b1;
      a = 1'b0;
      if (i >= LAT) begin
        e = vecs[i-LAT].en;
        a = vecs[i-LAT].ack;
      end
      applyStimulus(p, e, a);
      if (i >= LAT)
        checkOutput($sformatf("vec%0d", i - LAT), vecs[i-LAT].w, vecs[i-LAT].rdy,
                    vecs[i-LAT].ovf, vecs[i-LAT].lost);
    end

    // Leave a result pending and a pulse in progress, then reset asynchronously.
    repeat (3) applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    waitRdy(10);
    checkOutput("pendingBeforeReset", 3, 1, 0, 0);
    repeat (4) applyStimulus(1, 1, 0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncResetMidPulse", 0, 0, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (6 + LAT + 1) applyStimulus(1, 1, 0);
    checkOutput("highAtRelease", 0, 0, 0, 0);
    repeat (2 + LAT) applyStimulus(0, 1, 0);
    checkOutput("highAtReleaseEnd", 0, 0, 0, 0);
    repeat (3) applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    waitRdy(10);
    checkOutput("afterResetPulse", 3, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Receive-side counterpart of the pulse generator. It samples a single-bit pulse waveform, such as the generator's OUT line, and measures the width of each high pulse in clock cycles. Each measured width is presented on a 4-bit-compatible W_PUL_N bus with a ready/acknowledge handshake. The block closes the loop in loopback benches and is the decode side of pulse-width-coded control links.

## Interface
- WIDTH, 4: width of the measured-count bus. The count saturates at 2^WIDTH-1.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PUL_IN  in  1  pulse waveform to measure.
- EN  in  1  measurement enable. Low aborts any measurement in progress and re-arms the block.
- ACK  in  1  consumer acknowledge; acts only while RDY=1.
- W_PUL_N  out  WIDTH  last measured pulse width in cycles.
- RDY  out  1  result valid; held until acknowledged.
- OVF  out  1  last result saturated.
- LOST  out  1  sticky flag: a completed result was dropped because RDY was pending.

## Operation
- Reset values: W_PUL_N=0, RDY=0, OVF=0, LOST=0, internal count=0, FSM=WAIT_LOW, sampled-previous register=1.
- s is the sampled input: PUL_IN, or the synchronizer output (see Configuration).
- FSM states:
  - WAIT_LOW: ignore input until s=0, then go to IDLE. This prevents measuring a partial pulse after reset or after EN drops.
  - IDLE: on s=1, go to MEAS with cnt=1.
  - MEAS: while s=1, cnt increments, saturating at 2^WIDTH-1. Any attempted increment past saturation sets the internal ovf bit. On s=0, the pulse is complete: go to IDLE, attempt to commit the result, and clear cnt and ovf.
- EN=0: FSM goes to WAIT_LOW and cnt/ovf clear. W_PUL_N, RDY, OVF and LOST keep their values, and ACK still works.
- Commit rules:
  - RDY=0: W_PUL_N←cnt, OVF←ovf, RDY←1.
  - RDY=1 with ACK=1 in the same cycle: the new result loads, RDY stays 1, LOST is unchanged.
  - RDY=1 with ACK=0: the new result is discarded, the old W_PUL_N/OVF are kept, LOST←1.
- ACK with RDY=1 and no commit in that cycle: RDY←0, LOST←0. ACK with RDY=0 is ignored.
- Width arithmetic: the result equals the number of rising CLK edges at which s was sampled 1 during the pulse. The minimum result is 1. A result of 0 never occurs after a valid measurement.

## Timing
- Capture latency: RDY and W_PUL_N update on the first edge at which s is sampled 0 after the pulse, and are visible immediately after that edge. This is 0 added cycles without the synchronizer and 2 added cycles with it.
- Pulse spacing: a low gap of 1 sampled cycle is enough. A new rising s in the cycle after completion starts a new measurement with cnt=1.
- Handshake: RDY is a level and stays high until the first edge that samples ACK=1. RDY drops at that edge unless a commit coincides with it.
- Async reset mid-pulse: all outputs return to reset values immediately. After release, the block waits in WAIT_LOW, so a pulse already high is not measured.

## Configuration
- PWM_IN_SYNC_EN defined:
  - A two-flop synchronizer sits on PUL_IN; both flops reset to 1.
  - s lags PUL_IN by 2 cycles.
  - PUL_IN may be asynchronous.
- Not defined:
  - s=PUL_IN directly.
  - PUL_IN must be synchronous to CLK.
  - Measured widths are identical in both builds; only the latency differs.

## Test plan
- Reset with PUL_IN=0, then hold 3 cycles -> W_PUL_N=0, RDY=0, OVF=0, LOST=0; FSM reaches IDLE.
- 5-cycle high pulse, no ACK -> W_PUL_N=5, RDY=1, OVF=0 at the first low sample. ACK one cycle later -> RDY=0.
- 20-cycle high pulse, WIDTH=4 -> W_PUL_N=15, OVF=1, RDY=1. The next 3-cycle pulse after ACK -> W_PUL_N=3, OVF=0.
- Pulses of 4 then 7 cycles with no ACK -> W_PUL_N=4, LOST=1. ACK -> RDY=0, LOST=0.
- ACK asserted on exactly the completion edge of a 7-cycle pulse while the 4-cycle result is pending -> W_PUL_N=7, RDY=1, LOST=0.
- Two cases, each repeated in both builds (with and without PWM_IN_SYNC_EN):
  - PUL_IN high at reset release, then high for 6 more cycles -> no result (RDY=0).
  - RST_N pulsed low mid-pulse -> immediate return to reset values.
